// File: rtl/reduce_serial_param.sv
// rtl/reduce_serial_param.sv - serial chunked AND/OR/XOR/XNOR reduction of a WIDTH_I-bit vector
// Consumes CHUNK bits per RUN cycle, LSB chunk first; result registered on completion.
module reduce_serial_param #(
  parameter int WIDTH_I = 8,
  parameter int CHUNK   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH_I-1:0] in,
  output logic               busy,
  output logic               done,
  output logic               out
);

  localparam int N  = (CHUNK > 0) ? (WIDTH_I / CHUNK) : 1;
  localparam int CW = $clog2(N + 1);

  if (WIDTH_I < 1 || CHUNK < 1 || CHUNK > WIDTH_I || (WIDTH_I % CHUNK) != 0) begin : g_bad_param
    $error("reduce_serial_param: illegal WIDTH_I=%0d / CHUNK=%0d", WIDTH_I, CHUNK);
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  logic [WIDTH_I-1:0] sh;
  logic               acc;
  logic [1:0]         m;
  logic [CW-1:0]      cnt;
  logic [CHUNK-1:0]   chunk;
  logic               r;
  logic               acc_nxt;

  // XNOR folds with XOR and is inverted only once at the end.
  always_comb begin
    chunk = sh[CHUNK-1:0];
    case (m)
      2'b00:   r = &chunk;
      2'b01:   r = |chunk;
      default: r = ^chunk;
    endcase
    case (m)
      2'b00:   acc_nxt = acc & r;
      2'b01:   acc_nxt = acc | r;
      default: acc_nxt = acc ^ r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= 1'b0;
      acc   <= 1'b0;
      sh    <= '0;
      m     <= 2'b00;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            sh    <= in;
            m     <= mode;
            cnt   <= '0;
            acc   <= (mode == 2'b00);
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          sh  <= sh >> CHUNK;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            out   <= acc_nxt ^ (m == 2'b11);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reduce_serial_param.sv
// tb/tb_reduce_serial_param.sv - scoreboard bench for reduce_serial_param (8/2, 3/1, 3/3)
module tb_reduce_serial_param;

  typedef struct {
    logic o;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  logic       start8 = 1'b0;
  logic [1:0] mode8 = 2'b00;
  logic [7:0] in8 = 8'h00;
  logic       busy8, done8, out8;

  logic       start3 = 1'b0;
  logic [1:0] mode3 = 2'b00;
  logic [2:0] in3 = 3'b000;
  logic       busya, donea, outa;
  logic       busyb, doneb, outb;

  exp_t q8[$];
  exp_t qa[$];
  exp_t qb[$];

  reduce_serial_param #(.WIDTH_I(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .in(in8),
    .busy(busy8), .done(done8), .out(out8));

  reduce_serial_param #(.WIDTH_I(3), .CHUNK(1)) dut3a (
    .clk(clk), .rst(rst), .start(start3), .mode(mode3), .in(in3),
    .busy(busya), .done(donea), .out(outa));

  reduce_serial_param #(.WIDTH_I(3), .CHUNK(3)) dut3b (
    .clk(clk), .rst(rst), .start(start3), .mode(mode3), .in(in3),
    .busy(busyb), .done(doneb), .out(outb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitors: each done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      cmp("busy_with_done8", int'(busy8), 0);
      if (q8.size() == 0) cmp("unexpected_done8", 1, 0);
      else begin
        e = q8.pop_front();
        cmp("out8", int'(out8), int'(e.o));
        cmp("lat8", cyc, e.cyc);
      end
    end
    if (donea) begin
      if (qa.size() == 0) cmp("unexpected_done3a", 1, 0);
      else begin
        e = qa.pop_front();
        cmp("out3a", int'(outa), int'(e.o));
        cmp("lat3a", cyc, e.cyc);
      end
    end
    if (doneb) begin
      if (qb.size() == 0) cmp("unexpected_done3b", 1, 0);
      else begin
        e = qb.pop_front();
        cmp("out3b", int'(outb), int'(e.o));
        cmp("lat3b", cyc, e.cyc);
      end
    end
  end

  task automatic op8(input logic [1:0] md, input logic [7:0] v, input logic e);
    int bc;
    @(negedge clk);
    mode8 = md; in8 = v; start8 = 1'b1;
    q8.push_back('{o: e, cyc: cyc + 1 + 4});
    @(negedge clk);
    start8 = 1'b0; in8 = 8'($urandom); mode8 = 2'($urandom);
    bc = int'(busy8);
    repeat (5) begin
      @(negedge clk);
      bc += int'(busy8);
    end
    cmp("busy_cycles8", bc, 4);
  endtask

  initial begin
    logic [2:0] v;
    logic       e;

    repeat (2) @(negedge clk);
    cmp("rst_busy8", int'(busy8), 0);
    cmp("rst_done8", int'(done8), 0);
    cmp("rst_out8", int'(out8), 0);
    cmp("rst_out3a", int'(outa), 0);
    rst = 1'b0;

    op8(2'b00, 8'hFF, 1'b1);
    op8(2'b00, 8'hFE, 1'b0);
    op8(2'b01, 8'h00, 1'b0);
    op8(2'b01, 8'h80, 1'b1);
    op8(2'b10, 8'b1011_0000, 1'b1);
    op8(2'b11, 8'b1011_0000, 1'b0);

    // Start while busy is lost: only one done, result of the first operand.
    @(negedge clk);
    mode8 = 2'b00; in8 = 8'hFF; start8 = 1'b1;
    q8.push_back('{o: 1'b1, cyc: cyc + 1 + 4});
    @(negedge clk);
    in8 = 8'h00;
    repeat (2) @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    cmp("after_ignored_out8", int'(out8), 1);

    // Abort OR 8'h01 in its second RUN cycle.
    @(negedge clk);
    mode8 = 2'b01; in8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    cmp("abort_busy_before", int'(busy8), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("abort_busy", int'(busy8), 0);
    cmp("abort_done", int'(done8), 0);
    cmp("abort_out", int'(out8), 0);
    repeat (10) @(negedge clk);

    // rst and start together: start dropped.
    rst = 1'b1; start8 = 1'b1; mode8 = 2'b01; in8 = 8'hFF;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    cmp("rst_start_busy", int'(busy8), 0);
    repeat (6) @(negedge clk);

    for (int md = 0; md < 4; md++) begin
      for (int k = 0; k < 8; k++) begin
        v = 3'(k);
        case (md)
          0:       e = &v;
          1:       e = |v;
          2:       e = ^v;
          default: e = ~^v;
        endcase
        @(negedge clk);
        mode3 = 2'(md); in3 = v; start3 = 1'b1;
        qa.push_back('{o: e, cyc: cyc + 1 + 3});
        qb.push_back('{o: e, cyc: cyc + 1 + 1});
        @(negedge clk);
        start3 = 1'b0; in3 = 3'($urandom); mode3 = 2'($urandom);
        repeat (4) @(negedge clk);
      end
    end

    repeat (6) @(negedge clk);
    cmp("pending8", q8.size(), 0);
    cmp("pending3a", qa.size(), 0);
    cmp("pending3b", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
